// File: rtl/cache_req_adapter.sv
// cache_req_adapter
//   Buffers core memory requests, packs them into the 70-bit cache put request
//   {byte_en,tag,index,data,msi_valid,msi_data,ignore_response}, tracks in-flight
//   tags and turns the 52-bit cache row {tag,data,msi} into a core response with
//   a hit flag. One instance per core per cache.
//   Optional feature macro: CACHE_ADAPTER_STATS_EN (hit/miss counters).
module cache_req_adapter #(
  parameter int unsigned REQ_DEPTH = 2,
  parameter int unsigned TAG_DEPTH = 2,
  parameter int          CORE_ID   = 3,
  parameter int          CACHE_TY  = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic [3:0]  core_req_byte_en,
  input  logic [31:0] core_req_addr,
  input  logic [31:0] core_req_data,
  input  logic        core_req_msi_valid,
  input  logic [1:0]  core_req_msi_data,
  input  logic        core_req_ignore_resp,
  output logic        cache_put_valid,
  input  logic        cache_put_ready,
  output logic [69:0] cache_put_request,
  output logic        cache_get_valid,
  input  logic        cache_get_ready,
  input  logic [51:0] cache_get_response,
  output logic        core_resp_valid,
  input  logic        core_resp_ready,
  output logic        core_resp_hit,
  output logic [31:0] core_resp_data,
  output logic [1:0]  core_resp_msi,
  output logic [17:0] core_resp_tag,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
);

  localparam int unsigned RAW = $clog2(REQ_DEPTH);
  localparam int unsigned TAW = $clog2(TAG_DEPTH);

  // Request FIFO: packed requests, pointers carry an extra wrap bit
  logic [69:0]  req_mem [REQ_DEPTH];
  logic [RAW:0] req_wp, req_rp;
  logic         req_empty, req_full, req_push, req_pop;
  logic [69:0]  req_head, req_packed;

  // Tag queue: tags of issued requests that expect a response
  logic [17:0]  tag_mem [TAG_DEPTH];
  logic [TAW:0] tag_wp, tag_rp;
  logic         tag_empty, tag_full, tag_push, tag_pop;
  logic [17:0]  tag_head;

  // Response register
  logic         resp_valid_q, resp_hit_q;
  logic [31:0]  resp_data_q;
  logic [1:0]   resp_msi_q;
  logic [17:0]  resp_tag_q;

  logic         head_ignore, put_fire, get_fire, row_hit;
  logic [17:0]  row_tag;
  logic [31:0]  row_data;
  logic [1:0]   row_msi;

  // Address byte offset and the ID parameters are not consumed by the datapath
  logic unused_ok;
  assign unused_ok = &{1'b0, core_req_addr[1:0], CORE_ID[0], CACHE_TY[0]};

  // Request packing, FIFO status and handshake decode
  always_comb begin
    req_packed  = {core_req_byte_en, core_req_addr[31:14], core_req_addr[13:2],
                   core_req_data, core_req_msi_valid, core_req_msi_data,
                   core_req_ignore_resp};
    req_empty   = (req_wp == req_rp);
    req_full    = (req_wp[RAW] != req_rp[RAW]) &&
                  (req_wp[RAW-1:0] == req_rp[RAW-1:0]);
    tag_empty   = (tag_wp == tag_rp);
    tag_full    = (tag_wp[TAW] != tag_rp[TAW]) &&
                  (tag_wp[TAW-1:0] == tag_rp[TAW-1:0]);
    req_head    = req_mem[req_rp[RAW-1:0]];
    tag_head    = tag_mem[tag_rp[TAW-1:0]];
    head_ignore = req_head[0];

    core_req_ready    = !req_full;
    req_push          = core_req_valid && !req_full;
    cache_put_valid   = !req_empty && (head_ignore || !tag_full);
    cache_put_request = req_head;
    put_fire          = cache_put_valid && cache_put_ready;
    req_pop           = put_fire;
    tag_push          = put_fire && !head_ignore;

    cache_get_valid   = !tag_empty && (!resp_valid_q || core_resp_ready);
    get_fire          = cache_get_valid && cache_get_ready;
    tag_pop           = get_fire;

    row_tag  = cache_get_response[51:34];
    row_data = cache_get_response[33:2];
    row_msi  = cache_get_response[1:0];
    row_hit  = (row_tag == tag_head) && (row_msi != 2'b00);
  end

  // Request FIFO storage write
  always_ff @(posedge CLK) begin
    if (req_push) req_mem[req_wp[RAW-1:0]] <= req_packed;
  end

  // Tag queue storage write (tag field of the issuing head)
  always_ff @(posedge CLK) begin
    if (tag_push) tag_mem[tag_wp[TAW-1:0]] <= req_head[65:48];
  end

  // FIFO and tag queue pointers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_wp <= '0;
      req_rp <= '0;
      tag_wp <= '0;
      tag_rp <= '0;
    end else begin
      if (req_push) req_wp <= req_wp + {{RAW{1'b0}}, 1'b1};
      if (req_pop)  req_rp <= req_rp + {{RAW{1'b0}}, 1'b1};
      if (tag_push) tag_wp <= tag_wp + {{TAW{1'b0}}, 1'b1};
      if (tag_pop)  tag_rp <= tag_rp + {{TAW{1'b0}}, 1'b1};
    end
  end

  // Response register: load on get, drop on core accept, both in one cycle allowed
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
      resp_msi_q   <= '0;
      resp_tag_q   <= '0;
    end else if (get_fire) begin
      resp_valid_q <= 1'b1;
      resp_hit_q   <= row_hit;
      resp_data_q  <= row_data;
      resp_msi_q   <= row_msi;
      resp_tag_q   <= row_tag;
    end else if (core_resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  // Core response outputs
  always_comb begin
    core_resp_valid = resp_valid_q;
    core_resp_hit   = resp_hit_q;
    core_resp_data  = resp_data_q;
    core_resp_msi   = resp_msi_q;
    core_resp_tag   = resp_tag_q;
  end

`ifdef CACHE_ADAPTER_STATS_EN
  logic [31:0] hits_q, misses_q;

  // Saturating hit/miss counters, one event per get handshake
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (get_fire) begin
      if (row_hit) begin
        if (hits_q != '1) hits_q <= hits_q + 32'd1;
      end else begin
        if (misses_q != '1) misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_cache_req_adapter.sv
// tb_cache_req_adapter: directed vector table plus multi-cycle sequences,
// with a single-cycle cache model answering puts on the following cycle.
module tb_cache_req_adapter;

`ifdef CACHE_ADAPTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        core_req_valid, core_req_ready;
  logic [3:0]  core_req_byte_en;
  logic [31:0] core_req_addr, core_req_data;
  logic        core_req_msi_valid;
  logic [1:0]  core_req_msi_data;
  logic        core_req_ignore_resp;
  logic        cache_put_valid, cache_put_ready;
  logic [69:0] cache_put_request;
  logic        cache_get_valid, cache_get_ready;
  logic [51:0] cache_get_response;
  logic        core_resp_valid, core_resp_ready, core_resp_hit;
  logic [31:0] core_resp_data;
  logic [1:0]  core_resp_msi;
  logic [17:0] core_resp_tag;
  logic [31:0] stat_hits, stat_misses;

  cache_req_adapter #(.REQ_DEPTH(2), .TAG_DEPTH(2), .CORE_ID(3), .CACHE_TY(3)) dut (
    .CLK(CLK), .RST(RST),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_byte_en(core_req_byte_en), .core_req_addr(core_req_addr),
    .core_req_data(core_req_data), .core_req_msi_valid(core_req_msi_valid),
    .core_req_msi_data(core_req_msi_data), .core_req_ignore_resp(core_req_ignore_resp),
    .cache_put_valid(cache_put_valid), .cache_put_ready(cache_put_ready),
    .cache_put_request(cache_put_request),
    .cache_get_valid(cache_get_valid), .cache_get_ready(cache_get_ready),
    .cache_get_response(cache_get_response),
    .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_hit(core_resp_hit), .core_resp_data(core_resp_data),
    .core_resp_msi(core_resp_msi), .core_resp_tag(core_resp_tag),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 CLK = ~CLK;

  // Cache model: rows looked up by index[3:0], answered one cycle after the put
  logic [51:0] row_tbl [16];
  logic [51:0] qmem [8];
  logic [3:0]  wp, rp;
  logic [69:0] put_log [64];
  int          put_cnt = 0;

  assign cache_get_ready    = (wp != rp);
  assign cache_get_response = qmem[rp[2:0]];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (cache_put_valid && cache_put_ready) begin
        put_log[put_cnt] <= cache_put_request;
        put_cnt <= put_cnt + 1;
        if (!cache_put_request[0]) begin
          qmem[wp[2:0]] <= row_tbl[cache_put_request[39:36]];
          wp <= wp + 4'd1;
        end
      end
      if (cache_get_valid && cache_get_ready) rp <= rp + 4'd1;
    end
  end

  // Core response monitor: {hit,tag,data,msi} and accept cycle
  logic [52:0] resp_log [64];
  int          resp_cyc [64];
  int          resp_cnt = 0;
  int          cyc_cnt = 0;

  always @(posedge CLK) begin
    cyc_cnt <= cyc_cnt + 1;
    if (core_resp_valid && core_resp_ready) begin
      resp_log[resp_cnt] <= {core_resp_hit, core_resp_tag, core_resp_data, core_resp_msi};
      resp_cyc[resp_cnt] <= cyc_cnt;
      resp_cnt <= resp_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                      input logic ign);
    int t;
    core_req_addr        = a;
    core_req_byte_en     = be;
    core_req_data        = d;
    core_req_msi_valid   = 1'b0;
    core_req_msi_data    = 2'b00;
    core_req_ignore_resp = ign;
    core_req_valid       = 1'b1;
    t = 0;
    while (!core_req_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) begin
      chk("send_timeout", 70'd1, 70'd0);
    end else begin
      @(posedge CLK);
      @(negedge CLK);
    end
    core_req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target, input int limit);
    int t;
    t = 0;
    while (resp_cnt < target && t < limit) begin
      @(negedge CLK);
      t++;
    end
    if (resp_cnt < target) chk("resp_timeout", 70'(resp_cnt), 70'(target));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        msi_v;
    logic [1:0]  msi_d;
    logic [17:0] exp_tag;
    logic [11:0] exp_idx;
    logic [17:0] row_tag;
    logic [31:0] row_data;
    logic [1:0]  row_msi;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int base_put, base_resp, lat;
    bit got;
    logic [69:0] exp_req;

    vecs[0] = '{32'h0004_0008, 32'h0000_0000, 1'b0, 2'b00, 18'h00010, 12'h002,
                18'h00010, 32'hDEAD_BEEF, 2'b01, 1'b1};
    vecs[1] = '{32'h0004_0008, 32'h1111_2222, 1'b0, 2'b00, 18'h00010, 12'h002,
                18'h00011, 32'hDEAD_BEEF, 2'b01, 1'b0};
    vecs[2] = '{32'h0004_0008, 32'h0000_0000, 1'b1, 2'b10, 18'h00010, 12'h002,
                18'h00010, 32'hDEAD_BEEF, 2'b00, 1'b0};
    vecs[3] = '{32'hFFFF_FFFC, 32'hFFFF_0000, 1'b1, 2'b11, 18'h3FFFF, 12'hFFF,
                18'h3FFFF, 32'h1234_5678, 2'b11, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 2'b01, 18'h00000, 12'h000,
                18'h00000, 32'h0000_0000, 2'b10, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'hA5A5_5A5A, 1'b1, 2'b01, 18'h048D1, 12'h59E,
                18'h048D1, 32'hCAFE_F00D, 2'b10, 1'b1};

    for (int i = 0; i < 16; i++) row_tbl[i] = '0;
    RST = 1'b1;
    core_req_valid = 1'b0;
    core_req_byte_en = '0;
    core_req_addr = '0;
    core_req_data = '0;
    core_req_msi_valid = 1'b0;
    core_req_msi_data = '0;
    core_req_ignore_resp = 1'b0;
    cache_put_ready = 1'b1;
    core_resp_ready = 1'b1;
    repeat (3) @(negedge CLK);

    chk("rst_resp_valid", 70'(core_resp_valid), 70'd0);
    chk("rst_put_valid", 70'(cache_put_valid), 70'd0);
    chk("rst_get_valid", 70'(cache_get_valid), 70'd0);
    chk("rst_stat_hits", 70'(stat_hits), 70'd0);
    chk("rst_stat_misses", 70'(stat_misses), 70'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_req_ready", 70'(core_req_ready), 70'd1);

    // Single reads from the vector table: packing, latency, hit decode
    for (int i = 0; i < 6; i++) begin
      row_tbl[vecs[i].exp_idx[3:0]] = {vecs[i].row_tag, vecs[i].row_data, vecs[i].row_msi};
      base_put  = put_cnt;
      base_resp = resp_cnt;
      core_req_addr        = vecs[i].addr;
      core_req_byte_en     = 4'b0000;
      core_req_data        = vecs[i].wdata;
      core_req_msi_valid   = vecs[i].msi_v;
      core_req_msi_data    = vecs[i].msi_d;
      core_req_ignore_resp = 1'b0;
      core_req_valid       = 1'b1;
      chk($sformatf("v%0d_req_ready", i), 70'(core_req_ready), 70'd1);
      chk($sformatf("v%0d_no_bypass", i), 70'(cache_put_valid), 70'd0);
      got = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10 && !got; k++) begin
        @(posedge CLK);
        @(negedge CLK);
        if (k == 1) begin
          core_req_valid = 1'b0;
          chk($sformatf("v%0d_put_valid", i), 70'(cache_put_valid), 70'd1);
        end
        if (core_resp_valid) begin
          got = 1'b1;
          lat = k;
        end
      end
      chk($sformatf("v%0d_latency", i), 70'(lat), 70'd3);
      chk($sformatf("v%0d_hit", i), 70'(core_resp_hit), 70'(vecs[i].exp_hit));
      chk($sformatf("v%0d_data", i), 70'(core_resp_data), 70'(vecs[i].row_data));
      chk($sformatf("v%0d_msi", i), 70'(core_resp_msi), 70'(vecs[i].row_msi));
      chk($sformatf("v%0d_tag", i), 70'(core_resp_tag), 70'(vecs[i].row_tag));
      @(negedge CLK);
      exp_req = {4'b0000, vecs[i].exp_tag, vecs[i].exp_idx, vecs[i].wdata,
                 vecs[i].msi_v, vecs[i].msi_d, 1'b0};
      chk($sformatf("v%0d_put_cnt", i), 70'(put_cnt), 70'(base_put + 1));
      chk($sformatf("v%0d_put_req", i), put_log[base_put], exp_req);
      chk($sformatf("v%0d_resp_cnt", i), 70'(resp_cnt), 70'(base_resp + 1));
      if (vecs[i].exp_hit) exp_hits++;
      else exp_misses++;
    end
    chk("tbl_stat_hits", 70'(stat_hits), STATS ? 70'(exp_hits) : 70'd0);
    chk("tbl_stat_misses", 70'(stat_misses), STATS ? 70'(exp_misses) : 70'd0);

    // Ignore-response write followed by a read of the same address
    row_tbl[2] = {18'h00010, 32'h0BAD_F00D, 2'b01};
    base_put  = put_cnt;
    base_resp = resp_cnt;
    send(32'h0004_0008, 4'b0011, 32'h0000_A5A5, 1'b1);
    send(32'h0004_0008, 4'b0000, 32'h0000_0000, 1'b0);
    wait_resp(base_resp + 1, 20);
    repeat (10) @(negedge CLK);
    chk("ign_resp_cnt", 70'(resp_cnt), 70'(base_resp + 1));
    chk("ign_resp_data", 70'(resp_log[base_resp][33:2]), 70'h0BAD_F00D);
    chk("ign_resp_hit", 70'(resp_log[base_resp][52]), 70'd1);
    chk("ign_put_cnt", 70'(put_cnt), 70'(base_put + 2));
    chk("ign_put_write", put_log[base_put],
        {4'b0011, 18'h00010, 12'h002, 32'h0000_A5A5, 1'b0, 2'b00, 1'b1});
    chk("ign_put_read_flag", 70'(put_log[base_put + 1][0]), 70'd0);
    exp_hits++;

    // Backpressure: response held, tag queue and request FIFO fill up
    for (int i = 0; i < 6; i++) row_tbl[4 + i] = {18'h00000, 32'h1000_0000 + 32'(i), 2'b01};
    core_resp_ready = 1'b0;
    base_resp = resp_cnt;
    for (int i = 0; i < 5; i++) send(32'((4 + i) * 4), 4'b0000, 32'h0, 1'b0);
    chk("bp_req_ready", 70'(core_req_ready), 70'd0);
    chk("bp_put_stall", 70'(cache_put_valid), 70'd0);
    chk("bp_resp_valid", 70'(core_resp_valid), 70'd1);
    chk("bp_resp_head", 70'(core_resp_data), 70'h1000_0000);
    base_put = put_cnt;
    core_req_addr  = 32'(9 * 4);
    core_req_valid = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("bp_req_ready_hold", 70'(core_req_ready), 70'd0);
    end
    core_req_valid = 1'b0;
    chk("bp_put_frozen", 70'(put_cnt), 70'(base_put));
    core_resp_ready = 1'b1;
    wait_resp(base_resp + 5, 30);
    repeat (10) @(negedge CLK);
    chk("bp_resp_cnt", 70'(resp_cnt), 70'(base_resp + 5));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_order%0d", i), 70'(resp_log[base_resp + i][33:2]),
          70'(32'h1000_0000 + 32'(i)));
      chk($sformatf("bp_hit%0d", i), 70'(resp_log[base_resp + i][52]), 70'd1);
    end
    exp_hits += 5;

    // Back-to-back reads at full throughput
    for (int i = 0; i < 6; i++) row_tbl[i] = {18'h00000, 32'h2000_0000 + 32'(i), 2'b11};
    base_resp = resp_cnt;
    for (int i = 0; i < 6; i++) send(32'((16 + i) * 4), 4'b0000, 32'h0, 1'b0);
    wait_resp(base_resp + 6, 30);
    repeat (5) @(negedge CLK);
    chk("b2b_resp_cnt", 70'(resp_cnt), 70'(base_resp + 6));
    for (int i = 0; i < 6; i++)
      chk($sformatf("b2b_order%0d", i), 70'(resp_log[base_resp + i][33:2]),
          70'(32'h2000_0000 + 32'(i)));
    for (int i = 0; i < 5; i++)
      chk($sformatf("b2b_gap%0d", i),
          70'(resp_cyc[base_resp + i + 1] - resp_cyc[base_resp + i]), 70'd1);
    exp_hits += 6;
    chk("end_stat_hits", 70'(stat_hits), STATS ? 70'(exp_hits) : 70'd0);
    chk("end_stat_misses", 70'(stat_misses), STATS ? 70'(exp_misses) : 70'd0);

    // Asynchronous reset with requests in flight
    core_resp_ready = 1'b0;
    send(32'(24 * 4), 4'b0000, 32'h0, 1'b0);
    send(32'(25 * 4), 4'b0000, 32'h0, 1'b0);
    repeat (2) @(negedge CLK);
    chk("ar_in_flight", 70'(core_resp_valid), 70'd1);
    #1 RST = 1'b1;
    #1;
    chk("ar_resp_valid", 70'(core_resp_valid), 70'd0);
    chk("ar_put_valid", 70'(cache_put_valid), 70'd0);
    chk("ar_get_valid", 70'(cache_get_valid), 70'd0);
    chk("ar_stat_hits", 70'(stat_hits), 70'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    core_resp_ready = 1'b1;
    base_resp = resp_cnt;
    repeat (10) @(negedge CLK);
    chk("ar_no_stale", 70'(resp_cnt), 70'(base_resp));
    chk("ar_resp_idle", 70'(core_resp_valid), 70'd0);
    chk("ar_req_ready", 70'(core_req_ready), 70'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", cyc_cnt, 0);
    $fatal(1, "timeout");
  end

endmodule
